nn_mac_sequencer: RTL and testbench

Time-multiplexed fully-connected layer controller. It shares one signed multiply-accumulate unit across all output nodes of a layer, replacing the fully-parallel combinational network. On `start` it walks every (output node, input node) pair, issues read addresses to the input buffer and the weight ROM, and accumulates the products. It then writes one scaled, ReLU-clamped, saturated result per node into the output register file that the UART front end reads back.

---
 rtl/nn_mac_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_nn_mac_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/nn_mac_sequencer.sv
// nn_mac_sequencer
// Time-multiplexed fully-connected layer controller. One signed MAC is shared
// across every output node: for each node the sequencer streams INP_NODES
// (input, weight) address pairs, accumulates the products and writes one
// shifted, ReLU-clamped, saturated result into the output register file.
//
// Ports
//   clk_i        rising-edge clock
//   reset_i      asynchronous active-high reset
//   start_i      begin a layer (sampled in IDLE only)
//   abort_i      synchronous cancel of a running layer
//   busy_o       high from the cycle after start acceptance through DONE
//   done_o       one-cycle completion pulse
//   inp_addr_o   input buffer read address (data returns one cycle later)
//   inp_data_i   unsigned input activation
//   w_addr_o     weight ROM address, node*INP_NODES + i (running counter)
//   w_data_i     signed weight (returns one cycle after w_addr_o)
//   out_we_o     output register write strobe
//   out_addr_o   output node index
//   out_data_o   clamped result
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing one address pair per cycle for the current node
// DRAIN | absorbing the last product still in flight
// WRITE | result strobe for the current node
// DONE  | one-cycle completion pulse
`default_nettype none

module nn_mac_sequencer #(
    parameter int unsigned INP_BITS  = 6,
    parameter int unsigned W_BITS    = 8,
    parameter int unsigned OUT_BITS  = 10,
    parameter int unsigned INP_NODES = 381,
    parameter int unsigned OUT_NODES = 10,
    parameter int unsigned ACC_BITS  = 24,
    parameter int unsigned OUT_SHIFT = 0,
    localparam int unsigned IA_W = $clog2(INP_NODES),
    localparam int unsigned WA_W = $clog2(INP_NODES * OUT_NODES),
    localparam int unsigned OA_W = (OUT_NODES > 1) ? $clog2(OUT_NODES) : 1
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                start_i,
    input  logic                abort_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [IA_W-1:0]     inp_addr_o,
    input  logic [INP_BITS-1:0] inp_data_i,
    output logic [WA_W-1:0]     w_addr_o,
    input  logic [W_BITS-1:0]   w_data_i,
    output logic                out_we_o,
    output logic [OA_W-1:0]     out_addr_o,
    output logic [OUT_BITS-1:0] out_data_o
);

    localparam int unsigned P_W = INP_BITS + W_BITS + 1;
    localparam logic signed [ACC_BITS-1:0] OUT_MAX = ACC_BITS'((64'd1 << OUT_BITS) - 64'd1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_DRAIN = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                      state_q;
    logic                        busy_q;
    logic                        done_q;
    logic                        out_we_q;
    logic                        rd_valid_q;
    logic [IA_W-1:0]             inp_addr_q;
    logic [WA_W-1:0]             w_addr_q;
    logic [OA_W-1:0]             node_q;
    logic [OUT_BITS-1:0]         out_data_q;
    logic signed [ACC_BITS-1:0]  acc_q;

    logic signed [P_W-1:0]       inp_ext;
    logic signed [P_W-1:0]       w_ext;
    logic signed [P_W-1:0]       prod;
    logic signed [ACC_BITS-1:0]  acc_d;
    logic signed [ACC_BITS-1:0]  acc_sh;
    logic [OUT_BITS-1:0]         out_sat;
    logic                        last_i;
    logic                        last_node;

    // Activation is unsigned: a zero guard bit keeps it positive in the signed product.
    assign inp_ext = P_W'($signed({1'b0, inp_data_i}));
    assign w_ext   = P_W'($signed(w_data_i));
    assign prod    = inp_ext * w_ext;

    assign last_i    = (inp_addr_q == IA_W'(INP_NODES - 1));
    assign last_node = (node_q == OA_W'(OUT_NODES - 1));

    // acc_d already contains the product landing this cycle, so the DRAIN
    // cycle can register the final result without an extra pipeline stage.
    always_comb begin
        acc_d   = acc_q;
        acc_sh  = '0;
        out_sat = '0;
        if (rd_valid_q) begin
            acc_d = acc_q + ACC_BITS'(prod);
        end
        acc_sh = acc_d >>> OUT_SHIFT;
        if (acc_sh[ACC_BITS-1]) begin
            out_sat = '0;
        end else if (acc_sh > OUT_MAX) begin
            out_sat = '1;
        end else begin
            out_sat = acc_sh[OUT_BITS-1:0];
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            out_we_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            inp_addr_q <= '0;
            w_addr_q   <= '0;
            node_q     <= '0;
            out_data_q <= '0;
            acc_q      <= '0;
        end else begin
            out_we_q   <= 1'b0;
            done_q     <= 1'b0;
            acc_q      <= acc_d;
            rd_valid_q <= (state_q == S_RUN) && !abort_i;

            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q    <= S_RUN;
                        busy_q     <= 1'b1;
                        node_q     <= '0;
                        inp_addr_q <= '0;
                        w_addr_q   <= '0;
                        acc_q      <= '0;
                    end
                end
                S_RUN: begin
                    if (abort_i) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (last_i) begin
                        state_q <= S_DRAIN;
                    end else begin
                        inp_addr_q <= inp_addr_q + IA_W'(1);
                        w_addr_q   <= w_addr_q + WA_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (abort_i) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q    <= S_WRITE;
                        out_we_q   <= 1'b1;
                        out_data_q <= out_sat;
                    end
                end
                S_WRITE: begin
                    if (abort_i) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (last_node) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        // w_addr keeps counting into the next node's weight row.
                        state_q    <= S_RUN;
                        node_q     <= node_q + OA_W'(1);
                        inp_addr_q <= '0;
                        w_addr_q   <= w_addr_q + WA_W'(1);
                        acc_q      <= '0;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign out_we_o   = out_we_q;
    assign inp_addr_o = inp_addr_q;
    assign w_addr_o   = w_addr_q;
    assign out_addr_o = node_q;
    assign out_data_o = out_data_q;

endmodule

`default_nettype wire

// File: tb/tb_nn_mac_sequencer.sv
`timescale 1ns/1ps

module tb_nn_mac_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, abort, start2;
    logic       busy, done, out_we;
    logic [1:0] inp_addr;
    logic [2:0] w_addr;
    logic       out_addr;
    logic [9:0] out_data;
    logic [5:0] inp_data;
    logic [7:0] w_data;

    logic       busy2, done2, out_we2;
    logic [1:0] inp_addr2;
    logic [2:0] w_addr2;
    logic       out_addr2;
    logic [9:0] out_data2;
    logic [5:0] inp_data2;
    logic [7:0] w_data2;

    logic [5:0] inp_mem [4];
    logic [7:0] w_mem   [8];

    always #5 clk = ~clk;

    nn_mac_sequencer #(.INP_NODES(4), .OUT_NODES(2), .OUT_SHIFT(0)) dut (
        .clk_i(clk), .reset_i(reset), .start_i(start), .abort_i(abort),
        .busy_o(busy), .done_o(done), .inp_addr_o(inp_addr), .inp_data_i(inp_data),
        .w_addr_o(w_addr), .w_data_i(w_data), .out_we_o(out_we),
        .out_addr_o(out_addr), .out_data_o(out_data));

    nn_mac_sequencer #(.INP_NODES(4), .OUT_NODES(2), .OUT_SHIFT(2)) dut2 (
        .clk_i(clk), .reset_i(reset), .start_i(start2), .abort_i(1'b0),
        .busy_o(busy2), .done_o(done2), .inp_addr_o(inp_addr2), .inp_data_i(inp_data2),
        .w_addr_o(w_addr2), .w_data_i(w_data2), .out_we_o(out_we2),
        .out_addr_o(out_addr2), .out_data_o(out_data2));

    // Synchronous-read memories: data valid one cycle after the address.
    always @(posedge clk) begin
        inp_data  <= inp_mem[inp_addr];
        w_data    <= w_mem[w_addr];
        inp_data2 <= inp_mem[inp_addr2];
        w_data2   <= w_mem[w_addr2];
    end

    typedef struct {
        string name;
        int    inp [4];
        int    w   [8];
        int    exp0;
        int    exp1;
    } vec_t;

    vec_t vecs [7];

    int total = 0;
    int bad   = 0;

    int          wr_cnt, done_cnt, done_cyc, addr_err;
    int          wr_cyc [4];
    int          wr_adr [4];
    int          wr_dat [4];
    logic [31:0] busy_tr;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic load_vec(input int k);
        for (int j = 0; j < 4; j++) inp_mem[j] = 6'(vecs[k].inp[j]);
        for (int j = 0; j < 8; j++) w_mem[j] = 8'(vecs[k].w[j]);
    endtask

    // Start in cycle 0, then sample cycles 1..30 at the falling edge.
    task automatic run_layer(input int abort_at, input int extra_start,
                             input bit abort_with_start, input int reset_at);
        int exp_a;
        wr_cnt = 0; done_cnt = 0; done_cyc = -1; addr_err = 0; busy_tr = '0;
        for (int j = 0; j < 4; j++) begin wr_cyc[j] = -1; wr_adr[j] = -1; wr_dat[j] = -1; end
        @(negedge clk);
        start = 1'b1;
        abort = abort_with_start;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            reset = 1'b0;
            start = (cyc == extra_start);
            abort = (cyc == abort_at);
            if (out_we) begin
                if (wr_cnt < 4) begin
                    wr_cyc[wr_cnt] = cyc; wr_adr[wr_cnt] = int'(out_addr); wr_dat[wr_cnt] = int'(out_data);
                end
                wr_cnt++;
            end
            if (done) begin done_cnt++; done_cyc = cyc; end
            busy_tr[cyc] = busy;
            exp_a = -1;
            if (cyc >= 1 && cyc <= 4)  exp_a = cyc - 1;
            if (cyc >= 7 && cyc <= 10) exp_a = cyc - 3;
            if (exp_a >= 0 && (int'(w_addr) != exp_a || int'(inp_addr) != exp_a % 4)) addr_err++;
            if (cyc == reset_at) begin
                reset = 1'b1;
                #1;
                chk("rst_out_we", int'(out_we), 0);
                chk("rst_busy", int'(busy), 0);
                chk("rst_done", int'(done), 0);
                chk("rst_inp_addr", int'(inp_addr), 0);
                chk("rst_w_addr", int'(w_addr), 0);
                chk("rst_out_addr", int'(out_addr), 0);
                chk("rst_out_data", int'(out_data), 0);
            end
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic check_normal(input string tag, input int e0, input int e1);
        chk({tag, ".wr_cnt"}, wr_cnt, 2);
        chk({tag, ".wr0_cyc"}, wr_cyc[0], 6);
        chk({tag, ".wr1_cyc"}, wr_cyc[1], 12);
        chk({tag, ".wr0_addr"}, wr_adr[0], 0);
        chk({tag, ".wr1_addr"}, wr_adr[1], 1);
        chk({tag, ".wr0_data"}, wr_dat[0], e0);
        chk({tag, ".wr1_data"}, wr_dat[1], e1);
        chk({tag, ".done_cnt"}, done_cnt, 1);
        chk({tag, ".done_cyc"}, done_cyc, 13);
        chk({tag, ".busy_trace"}, int'(busy_tr), 32'h0000_3FFE);
        chk({tag, ".addr_err"}, addr_err, 0);
    endtask

    initial begin
        vecs[0] = '{"ones",    '{1,1,1,1},     '{1,1,1,1, 1,1,1,1},           4,    4};
        vecs[1] = '{"relu",    '{1,1,1,1},     '{-1,-1,-1,-1, -1,-1,-1,-1},   0,    0};
        vecs[2] = '{"alt",     '{2,2,2,2},     '{3,-1,3,-1, 3,-1,3,-1},       8,    8};
        vecs[3] = '{"sat",     '{63,63,63,63}, '{127,127,127,127, 127,127,127,127}, 1023, 1023};
        vecs[4] = '{"ramp",    '{1,2,3,4},     '{1,1,1,1, 2,2,2,2},           10,   20};
        vecs[5] = '{"mixed",   '{10,20,30,40}, '{5,-2,1,-1, -1,-1,-1,20},     0,    740};
        vecs[6] = '{"edge",    '{32,32,32,32}, '{8,8,8,8, 8,8,8,7},           1023, 992};

        reset = 1'b1; start = 1'b0; abort = 1'b0; start2 = 1'b0;
        for (int j = 0; j < 4; j++) inp_mem[j] = '0;
        for (int j = 0; j < 8; j++) w_mem[j] = '0;
        repeat (3) @(negedge clk);
        chk("reset.busy", int'(busy), 0);
        chk("reset.out_we", int'(out_we), 0);
        chk("reset.w_addr", int'(w_addr), 0);
        reset = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 7; k++) begin
            load_vec(k);
            run_layer(-1, -1, 1'b0, -1);
            check_normal(vecs[k].name, vecs[k].exp0, vecs[k].exp1);
        end

        // Abort in node 1 RUN (cycle 8): IDLE from cycle 9, one write, no done.
        load_vec(0);
        run_layer(8, -1, 1'b0, -1);
        chk("abort.wr_cnt", wr_cnt, 1);
        chk("abort.done_cnt", done_cnt, 0);
        chk("abort.busy_trace", int'(busy_tr), 32'h0000_01FE);
        run_layer(-1, -1, 1'b0, -1);
        check_normal("after_abort", 4, 4);

        // start pulsed while busy is ignored.
        run_layer(-1, 5, 1'b0, -1);
        check_normal("start_busy", 4, 4);

        // start and abort together in IDLE: start wins.
        run_layer(-1, -1, 1'b1, -1);
        check_normal("start_abort", 4, 4);

        // Back-to-back: start in the cycle after done.
        run_layer(-1, 14, 1'b0, -1);
        chk("b2b.wr_cnt", wr_cnt, 4);
        chk("b2b.wr2_cyc", wr_cyc[2], 20);
        chk("b2b.wr3_cyc", wr_cyc[3], 26);
        chk("b2b.wr3_data", wr_dat[3], 4);
        chk("b2b.done_cnt", done_cnt, 2);
        chk("b2b.busy_trace", int'(busy_tr), 32'h0FFF_BFFE);

        // Async reset in the first WRITE cycle.
        run_layer(-1, -1, 1'b0, 6);
        chk("rst.wr_cnt", wr_cnt, 1);
        chk("rst.done_cnt", done_cnt, 0);
        chk("rst.busy_trace", int'(busy_tr), 32'h0000_007E);
        run_layer(-1, -1, 1'b0, -1);
        check_normal("after_rst", 4, 4);

        // OUT_SHIFT=2 instance: 13>>>2 = 3, 7>>>2 = 1.
        inp_mem = '{1, 1, 1, 1};
        w_mem   = '{8'd3, 8'd3, 8'd3, 8'd4, 8'd2, 8'd2, 8'd2, 8'd1};
        wr_cnt = 0;
        for (int j = 0; j < 4; j++) begin wr_cyc[j] = -1; wr_dat[j] = -1; end
        @(negedge clk);
        start2 = 1'b1;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            @(negedge clk);
            start2 = 1'b0;
            if (out_we2) begin
                if (wr_cnt < 4) begin wr_cyc[wr_cnt] = cyc; wr_dat[wr_cnt] = int'(out_data2); end
                wr_cnt++;
            end
        end
        chk("shift.wr_cnt", wr_cnt, 2);
        chk("shift.wr0_cyc", wr_cyc[0], 6);
        chk("shift.wr0_data", wr_dat[0], 3);
        chk("shift.wr1_data", wr_dat[1], 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
